// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC prefix, LSB-first serialization, bit stuffing,
// NRZI line coding and EOP generation, one line bit every CLKS_PER_BIT clocks.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_active,
  output logic       tx_err,
  output logic [2:0] dbg_state_o
);
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP_SE0, S_EOP_J} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_data_q;
  logic            hold_last_q;
  logic            hold_full_q, hold_full_d;
  logic            cur_last_q, cur_last_d;
  logic [2:0]      ones_q, ones_d;
  logic            k_q, k_d;
  logic            se0_q, se0_d;
  logic            err_q, err_d;
  logic            wrap, accept, drain;
  logic            send, send_bit, load_byte, go_eop;

  // Handshake: a byte moves when tx_valid && tx_ready at a rising clk edge; the source
  // must hold tx_data/tx_last stable while tx_ready is low.
  assign tx_ready    = !hold_full_q && (state_q != S_EOP_SE0) && (state_q != S_EOP_J);
  assign accept      = tx_valid && tx_ready;
  assign wrap        = (timer_q == TW'(CLKS_PER_BIT - 1));
  assign d_plus      = !se0_q && !k_q;
  assign d_minus     = !se0_q && k_q;
  assign tx_active   = (state_q != S_IDLE);
  assign tx_err      = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    timer_d     = (state_q == S_IDLE || wrap) ? '0 : timer_q + TW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    cur_last_d  = cur_last_q;
    ones_d      = ones_q;
    k_d         = k_q;
    se0_d       = se0_q;
    err_d       = 1'b0;
    drain       = 1'b0;
    send        = 1'b0;
    send_bit    = 1'b0;
    load_byte   = 1'b0;
    go_eop      = 1'b0;
    hold_full_d = hold_full_q;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          state_d = S_SYNC;
          k_d     = 1'b1;
          se0_d   = 1'b0;
          bit_d   = 3'd0;
          ones_d  = 3'd0;
        end
      end
      S_SYNC: begin
        if (wrap) begin
          if (bit_q != 3'd7) begin
            bit_d    = bit_q + 3'd1;
            send     = 1'b1;
            send_bit = (bit_q == 3'd6);
          end else begin
            load_byte = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (wrap) begin
          // A pending stuff bit goes out before the next data bit or the EOP.
          if (ones_q == 3'd6) begin
            send     = 1'b1;
            send_bit = 1'b0;
          end else if (bit_q != 3'd7) begin
            bit_d    = bit_q + 3'd1;
            shift_d  = shift_q >> 1;
            send     = 1'b1;
            send_bit = shift_q[1];
          end else if (cur_last_q) begin
            go_eop = 1'b1;
          end else begin
            load_byte = 1'b1;
          end
        end
      end
      S_EOP_SE0: begin
        if (wrap) begin
          if (bit_q == 3'd0) begin
            bit_d = 3'd1;
          end else begin
            state_d = S_EOP_J;
            se0_d   = 1'b0;
            k_d     = 1'b0;
          end
        end
      end
      S_EOP_J: begin
        if (wrap) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_byte) begin
      if (hold_full_q) begin
        state_d    = S_DATA;
        shift_d    = hold_data_q;
        cur_last_d = hold_last_q;
        drain      = 1'b1;
        bit_d      = 3'd0;
        send       = 1'b1;
        send_bit   = hold_data_q[0];
      end else begin
        err_d  = 1'b1;
        go_eop = 1'b1;
      end
    end

    if (go_eop) begin
      state_d = S_EOP_SE0;
      se0_d   = 1'b1;
      bit_d   = 3'd0;
    end

    // NRZI: a zero toggles the line and breaks the run of ones.
    if (send) begin
      if (!send_bit) begin
        k_d    = !k_q;
        ones_d = 3'd0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end

    if (drain)  hold_full_d = 1'b0;
    if (accept) hold_full_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      cur_last_q <= 1'b0;
      ones_q     <= 3'd0;
      k_q        <= 1'b0;
      se0_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      cur_last_q <= cur_last_d;
      ones_q     <= ones_d;
      k_q        <= k_d;
      se0_q      <= se0_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= 8'd0;
      hold_last_q <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      if (accept) begin
        hold_data_q <= tx_data;
        hold_last_q <= tx_last;
      end
    end
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: an 8-clock and a 4-clock instance, line symbols checked every
// clock against a reference encoding of the offered bytes.
module tb_usb_tx_encoder;
  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [7:0] tx_data_r[2];
  logic       tx_valid_r[2];
  logic       tx_last_r[2];
  logic       tx_ready_w[2];
  logic       dp_w[2];
  logic       dm_w[2];
  logic       act_w[2];
  logic       err_w[2];
  logic [2:0] dbg_w[2];

  usb_tx_encoder #(.CLKS_PER_BIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .tx_data(tx_data_r[0]), .tx_valid(tx_valid_r[0]),
    .tx_last(tx_last_r[0]), .tx_ready(tx_ready_w[0]), .d_plus(dp_w[0]), .d_minus(dm_w[0]),
    .tx_active(act_w[0]), .tx_err(err_w[0]), .dbg_state_o(dbg_w[0])
  );

  usb_tx_encoder #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .tx_data(tx_data_r[1]), .tx_valid(tx_valid_r[1]),
    .tx_last(tx_last_r[1]), .tx_ready(tx_ready_w[1]), .d_plus(dp_w[1]), .d_minus(dm_w[1]),
    .tx_active(act_w[1]), .tx_err(err_w[1]), .dbg_state_o(dbg_w[1])
  );

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_q[$];
  logic [7:0] byte_q[$];

  function automatic int cpb(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  // Reference: SYNC + bytes LSB-first, stuff a 0 after every six 1s, NRZI, then SE0 SE0 J.
  task automatic build_expected();
    bit raw[$];
    int ones;
    logic [1:0] lvl;
    logic [7:0] b;
    logic [7:0] sync;
    exp_q.delete();
    sync = 8'h80;
    for (int i = 0; i < 8; i++) raw.push_back(sync[i]);
    foreach (byte_q[j]) begin
      b = byte_q[j];
      for (int i = 0; i < 8; i++) raw.push_back(b[i]);
    end
    ones = 0;
    lvl = LJ;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = (lvl == LJ) ? LK : LJ;
      exp_q.push_back(lvl);
      if (raw[i]) ones++;
      else ones = 0;
      if (ones == 6) begin
        lvl = (lvl == LJ) ? LK : LJ;
        exp_q.push_back(lvl);
        ones = 0;
      end
    end
    exp_q.push_back(LSE0);
    exp_q.push_back(LSE0);
    exp_q.push_back(LJ);
  endtask

  // driver: offers every byte of byte_q in order; called and returns at a negedge
  task automatic drive_bytes(input int d, input bit final_last);
    int t;
    for (int i = 0; i < byte_q.size(); i++) begin
      tx_data_r[d]  = byte_q[i];
      tx_last_r[d]  = final_last && (i == byte_q.size() - 1);
      tx_valid_r[d] = 1'b1;
      t = 0;
      while (!tx_ready_w[d] && t < 400) begin
        @(negedge clk);
        t++;
      end
      if (t >= 400) begin
        checks++;
        failures++;
        $display("FAIL drive_timeout dut%0d byte%0d tx_ready=0 required 1", d, i);
        tx_valid_r[d] = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      tx_valid_r[d] = 1'b0;
    end
  endtask

  // scoreboard consumer: pops one line symbol per bit time and checks every clock of it
  task automatic check_packet(input int d, input int exp_err, input string tag);
    int n, t, err_cnt, err_sym;
    logic [1:0] e;
    n = exp_q.size();
    t = 0;
    err_cnt = 0;
    err_sym = -1;
    while (1) begin
      @(negedge clk);
      if (act_w[d]) break;
      t++;
      if (t >= 300) break;
    end
    checks++;
    if (act_w[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s start_timeout dut%0d tx_active=%b required 1", tag, d, act_w[d]);
      exp_q.delete();
      return;
    end
    for (int s = 0; s < n; s++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < cpb(d); k++) begin
        checks++;
        if ({act_w[d], dp_w[d], dm_w[d]} !== {1'b1, e}) begin
          failures++;
          $display("FAIL %s line sym%0d clk%0d act/dp/dm=%b%b%b required 1%b", tag, s, k,
                   act_w[d], dp_w[d], dm_w[d], e);
        end
        if (err_w[d]) begin
          err_cnt++;
          err_sym = s;
        end
        @(negedge clk);
      end
    end
    checks++;
    if ({act_w[d], dp_w[d], dm_w[d], tx_ready_w[d]} !== 4'b0101) begin
      failures++;
      $display("FAIL %s end_idle act/dp/dm/ready=%b%b%b%b required 0101", tag,
               act_w[d], dp_w[d], dm_w[d], tx_ready_w[d]);
    end
    checks++;
    if (err_cnt != exp_err) begin
      failures++;
      $display("FAIL %s err_count got %0d required %0d", tag, err_cnt, exp_err);
    end
    if (exp_err > 0) begin
      checks++;
      if (err_sym != n - 3) begin
        failures++;
        $display("FAIL %s err_position got sym%0d required sym%0d", tag, err_sym, n - 3);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({act_w[d], tx_ready_w[d], dp_w[d], dm_w[d], err_w[d], dbg_w[d]} !== 8'b01100_000) begin
        failures++;
        $display("FAIL reset dut%0d act/rdy/dp/dm/err/state=%b%b%b%b%b/%0d required 01100/0", d,
                 act_w[d], tx_ready_w[d], dp_w[d], dm_w[d], err_w[d], dbg_w[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single(input int d, input logic [7:0] b, input string tag);
    byte_q = '{b};
    build_expected();
    drive_bytes(d, 1'b1);
    check_packet(d, 0, tag);
  endtask

  task automatic test_back_to_back(input string tag);
    build_expected();
    fork
      drive_bytes(0, 1'b1);
      check_packet(0, 0, tag);
    join
  endtask

  task automatic test_underrun();
    byte_q = '{8'h01};
    build_expected();
    drive_bytes(0, 1'b0);
    check_packet(0, 1, "underrun");
  endtask

  task automatic test_reset_mid_packet();
    int t;
    byte_q = '{8'h55};
    drive_bytes(0, 1'b1);
    t = 0;
    while (!act_w[0] && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (10 * 8 + 3) @(negedge clk);
    checks++;
    if (act_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_pre tx_active=%b required 1", act_w[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dp_w[0], dm_w[0], act_w[0], tx_ready_w[0]} !== 4'b1001) begin
      failures++;
      $display("FAIL mid_reset dp/dm/act/rdy=%b%b%b%b required 1001", dp_w[0], dm_w[0],
               act_w[0], tx_ready_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_single(0, 8'h00, "after_reset");
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      tx_data_r[d]  = 8'h00;
      tx_valid_r[d] = 1'b0;
      tx_last_r[d]  = 1'b0;
    end
    rst = 1'b1;
    test_reset();
    test_single(0, 8'h00, "byte_00");
    test_single(0, 8'hFF, "byte_ff");
    byte_q = '{8'hA5, 8'h3C};
    test_back_to_back("a5_3c");
    test_underrun();
    test_reset_mid_packet();
    test_single(1, 8'h7E, "cpb4_7e");
    for (int r = 0; r < 3; r++) begin
      byte_q.delete();
      for (int i = 0; i < 3; i++) byte_q.push_back(8'($urandom_range(0, 255)));
      test_back_to_back("random");
    end
    byte_q = '{8'hFF, 8'hFF, 8'h3F};
    test_back_to_back("long_ones");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
